// File: rtl/vga_pkg.sv
// vga_pkg
// Shared types and helpers for the VGA scan-out slice:
//   timing_t        - one video mode, visible/porch/sync lengths per axis
//   SVGA_800x600    - 800x600 @ 60 Hz mode (40 MHz pixel clock)
//   VGA_640x480     - 640x480 @ 60 Hz mode (25.175 MHz pixel clock)
//   rgb12_t         - 4:4:4 colour as driven on the board pins
//   pix_flags_t     - per-pixel flags carried down the latency-matching delay line
//   cnt_w()         - counter width needed to hold values 0..n-1
//   mandelbrot_color() - escape count to colour palette
package vga_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_front;
    logic [15:0] h_sync;
    logic [15:0] h_back;
    logic [15:0] v_active;
    logic [15:0] v_front;
    logic [15:0] v_sync;
    logic [15:0] v_back;
  } timing_t;

  localparam timing_t SVGA_800x600 = '{
    h_active: 16'd800, h_front: 16'd40, h_sync: 16'd128, h_back: 16'd88,
    v_active: 16'd600, v_front: 16'd1,  v_sync: 16'd4,   v_back: 16'd23
  };

  localparam timing_t VGA_640x480 = '{
    h_active: 16'd640, h_front: 16'd16, h_sync: 16'd96, h_back: 16'd48,
    v_active: 16'd480, v_front: 16'd10, v_sync: 16'd2,  v_back: 16'd33
  };

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef struct packed {
    logic frame0;
    logic vblank;
    logic vsync_on;
    logic hsync_on;
    logic in_active;
    logic in_image;
  } pix_flags_t;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Points inside the set (count saturated at 255) are black; escaping
  // points take red from the low nibble, green from the high nibble and
  // blue from the middle bits so neighbouring bands stay distinguishable.
  function automatic rgb12_t mandelbrot_color(input logic [7:0] n);
    rgb12_t c;
    if (n == 8'hFF) begin
      c = '0;
    end else begin
      c.r = n[3:0];
      c.g = n[7:4];
      c.b = n[5:2];
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster counters and the undelayed timing flags derived from them.
// Ports:
//   clk, reset         pixel clock, synchronous active-high reset
//   h_cnt, v_cnt       current column / line
//   h_last, v_last     counter sits on its final value
//   h_active, v_active counter is inside the visible region
//   hsync_on, vsync_on counter is inside the sync pulse (polarity-free)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 23,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW      = cnt_w(H_TOTAL),
  localparam int VW      = cnt_w(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          h_last,
  output logic          v_last,
  output logic          h_active,
  output logic          v_active,
  output logic          hsync_on,
  output logic          vsync_on
);

  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int VS_START = V_ACTIVE + V_FRONT;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign h_active = (h_cnt < HW'(H_ACTIVE));
  assign v_active = (v_cnt < VW'(V_ACTIVE));
  assign hsync_on = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_START + H_SYNC));
  assign vsync_on = (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_START + V_SYNC));

endmodule

// File: rtl/vga_scaled_display.sv
// vga_scaled_display
// VGA scan-out engine: raster timing, scaled/offset image window over tiled
// VRAM, latency-matched sync/colour outputs and frame-synchronous buffer select.
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   frame_sel             requested display buffer (taken at end of frame)
//   VRAM_addr, VRAM_en    registered read request, enabled only in the image
//   VRAM_data             escape count, RAM_LATENCY cycles after the address
//   VGA_hsync, VGA_vsync  sync pins, aligned with the colour pins
//   VGA_R, VGA_G, VGA_B   4-bit colour pins
//   buf_active            buffer used for the frame now being fetched
//   frame_start           one-cycle pulse with the first output pixel of a frame
//   vblank                vertical blanking, aligned with the pins
module vga_scaled_display
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE    = int'(SVGA_800x600.h_active),
  parameter int          H_FRONT     = int'(SVGA_800x600.h_front),
  parameter int          H_SYNC      = int'(SVGA_800x600.h_sync),
  parameter int          H_BACK      = int'(SVGA_800x600.h_back),
  parameter int          V_ACTIVE    = int'(SVGA_800x600.v_active),
  parameter int          V_FRONT     = int'(SVGA_800x600.v_front),
  parameter int          V_SYNC      = int'(SVGA_800x600.v_sync),
  parameter int          V_BACK      = int'(SVGA_800x600.v_back),
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int          IMG_W_LOG2  = 8,
  parameter int          IMG_H_LOG2  = 8,
  parameter int          TILE_LOG2   = 6,
  parameter int          SCALE_LOG2  = 1,
  parameter int          X_OFFSET    = 144,
  parameter int          Y_OFFSET    = 44,
  parameter int          RAM_LATENCY = 1,
  parameter int          ADDR_W      = 18,
  parameter logic [11:0] BORDER_RGB  = 12'h112
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_sel,
  output logic [ADDR_W-1:0] VRAM_addr,
  output logic              VRAM_en,
  input  logic [7:0]        VRAM_data,
  output logic              VGA_hsync,
  output logic              VGA_vsync,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              buf_active,
  output logic              frame_start,
  output logic              vblank
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW       = cnt_w(H_TOTAL);
  localparam int VW       = cnt_w(V_TOTAL);
  localparam int XPW      = IMG_W_LOG2 + SCALE_LOG2;
  localparam int YPW      = IMG_H_LOG2 + SCALE_LOG2;
  localparam int IMG_W_SC = 1 << XPW;
  localparam int IMG_H_SC = 1 << YPW;
  localparam int LAT      = RAM_LATENCY + 2;
  localparam int DLY_N    = LAT - 1;
  // The position counters are cleared on the cycle before the window opens,
  // wrapping around to the last column/line when the window starts at zero.
  localparam int X_LOAD   = (X_OFFSET == 0) ? H_TOTAL - 1 : X_OFFSET - 1;
  localparam int Y_LOAD   = (Y_OFFSET == 0) ? V_TOTAL - 1 : Y_OFFSET - 1;

  if (IMG_W_LOG2 + IMG_H_LOG2 + 1 > ADDR_W) begin : g_chk_addr
    $fatal(1, "vga_scaled_display: ADDR_W too small for image plus buffer bit");
  end
  if (TILE_LOG2 > IMG_W_LOG2 || TILE_LOG2 > IMG_H_LOG2) begin : g_chk_tile
    $fatal(1, "vga_scaled_display: tile larger than image");
  end
  if (X_OFFSET + IMG_W_SC > H_ACTIVE || Y_OFFSET + IMG_H_SC > V_ACTIVE) begin : g_chk_fit
    $fatal(1, "vga_scaled_display: scaled image does not fit the active area");
  end
  if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_chk_lat
    $fatal(1, "vga_scaled_display: RAM_LATENCY must be 1..4");
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, h_active, v_active, hsync_on, vsync_on;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .h_last   (h_last),
    .v_last   (v_last),
    .h_active (h_active),
    .v_active (v_active),
    .hsync_on (hsync_on),
    .vsync_on (vsync_on)
  );

  // Screen position relative to the image origin, kept in step with the
  // raster counters. The image coordinate is the top bits, so pixel
  // replication falls out of dropping the SCALE_LOG2 low bits.
  logic [XPW-1:0] x_pos;
  logic [YPW-1:0] y_pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_pos <= '0;
      y_pos <= '0;
    end else begin
      if (h_cnt == HW'(X_LOAD)) x_pos <= '0;
      else                      x_pos <= x_pos + XPW'(1);
      if (h_last) begin
        if (v_cnt == VW'(Y_LOAD)) y_pos <= '0;
        else                      y_pos <= y_pos + YPW'(1);
      end
    end
  end

  logic [IMG_W_LOG2-1:0] img_x;
  logic [IMG_H_LOG2-1:0] img_y;
  logic                  x_win, y_win;
  pix_flags_t            flags;
  logic [ADDR_W-1:0]     addr_img;

  assign img_x = x_pos[XPW-1 -: IMG_W_LOG2];
  assign img_y = y_pos[YPW-1 -: IMG_H_LOG2];
  assign x_win = (h_cnt >= HW'(X_OFFSET)) && (h_cnt < HW'(X_OFFSET + IMG_W_SC));
  assign y_win = (v_cnt >= VW'(Y_OFFSET)) && (v_cnt < VW'(Y_OFFSET + IMG_H_SC));

  always_comb begin
    flags           = '0;
    flags.in_image  = x_win && y_win;
    flags.in_active = h_active && v_active;
    flags.hsync_on  = hsync_on;
    flags.vsync_on  = vsync_on;
    flags.vblank    = !v_active;
    flags.frame0    = (h_cnt == '0) && (v_cnt == '0);
  end

  // Tiled layout {buf, y_hi, x_hi, y_lo, x_lo}, assembled with shifts so a
  // tile as wide as the image (empty hi fields) needs no special casing.
  always_comb begin
    logic [ADDR_W-1:0] ax, ay, tmask;
    ax       = ADDR_W'(img_x);
    ay       = ADDR_W'(img_y);
    tmask    = ADDR_W'((1 << TILE_LOG2) - 1);
    addr_img = ((ay >> TILE_LOG2) << (IMG_W_LOG2 + TILE_LOG2))
             | ((ax >> TILE_LOG2) << (2 * TILE_LOG2))
             | ((ay & tmask) << TILE_LOG2)
             | (ax & tmask)
             | (ADDR_W'(buf_active) << (IMG_W_LOG2 + IMG_H_LOG2));
  end

  // Buffer select only changes on the last pixel of a frame, so every
  // fetch of one frame carries the same buffer bit.
  always_ff @(posedge clk) begin
    if (reset)                 buf_active <= 1'b0;
    else if (h_last && v_last) buf_active <= frame_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      VRAM_addr <= '0;
      VRAM_en   <= 1'b0;
    end else begin
      VRAM_addr <= flags.in_image ? addr_img : '0;
      VRAM_en   <= flags.in_image;
    end
  end

  // Flags ride a DLY_N-deep line; together with the output register this
  // matches the address register plus RAM latency, so the flag arriving at
  // the output stage belongs to the same pixel as VRAM_data.
  pix_flags_t dly [DLY_N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DLY_N; i++) dly[i] <= '0;
    end else begin
      dly[0] <= flags;
      for (int i = 1; i < DLY_N; i++) dly[i] <= dly[i-1];
    end
  end

  pix_flags_t d_out;
  rgb12_t     rgb_q;

  assign d_out = dly[DLY_N-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q       <= '0;
      VGA_hsync   <= ~HSYNC_POL;
      VGA_vsync   <= ~VSYNC_POL;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      if (d_out.in_image)       rgb_q <= mandelbrot_color(VRAM_data);
      else if (d_out.in_active) rgb_q <= rgb12_t'(BORDER_RGB);
      else                      rgb_q <= '0;
      VGA_hsync   <= d_out.hsync_on ? HSYNC_POL : ~HSYNC_POL;
      VGA_vsync   <= d_out.vsync_on ? VSYNC_POL : ~VSYNC_POL;
      frame_start <= d_out.frame0;
      vblank      <= d_out.vblank;
    end
  end

  assign VGA_R = rgb_q.r;
  assign VGA_G = rgb_q.g;
  assign VGA_B = rgb_q.b;

endmodule

// File: doc/vga_scaled_display.md
Name: vga_scaled_display

Overview:
- Parametrised VGA scan-out engine: generates raster timing, fetches escape counts from tiled VRAM, and drives 12-bit RGB through the mandelbrot_color mapper.
- Generalises the fixed 800x600 / 256x256 / 1-cycle-latency controller with:
  - programmable timing;
  - integer pixel replication and image placement offsets;
  - configurable RAM latency, with sync and RGB aligned;
  - a border colour;
  - frame-synchronous double-buffer select.
- Sits between the VRAM read port and the board VGA pins.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch
- H_SYNC, 128, horizontal sync width
- H_BACK, 88, horizontal back porch
- V_ACTIVE, 600, visible lines
- V_FRONT, 1, vertical front porch
- V_SYNC, 4, vertical sync width
- V_BACK, 23, vertical back porch
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync
- IMG_W_LOG2, 8, log2 of image width in image pixels
- IMG_H_LOG2, 8, log2 of image height in image pixels
- TILE_LOG2, 6, log2 of square tile side
- SCALE_LOG2, 1, each image pixel is replicated 2^SCALE_LOG2 times horizontally and vertically
- X_OFFSET, 144, first screen column of the image
- Y_OFFSET, 44, first screen line of the image
- RAM_LATENCY, 1, VRAM read latency in cycles, legal range 1..4
- ADDR_W, 18, VRAM address width
- BORDER_RGB, 12'h112, colour shown in the active area outside the image

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- frame_sel  in  1  requested display buffer
- VRAM_addr  out  ADDR_W  read address
- VRAM_en  out  1  read enable; high only for in-image fetches
- VRAM_data  in  8  escape count, valid RAM_LATENCY cycles after the address
- VGA_hsync  out  1  horizontal sync
- VGA_vsync  out  1  vertical sync
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue
- buf_active  out  1  buffer currently scanned out
- frame_start  out  1  one-cycle pulse at the first output pixel of each frame
- vblank  out  1  output-aligned vertical blanking flag

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Counters:
  - h_cnt runs 0..H_TOTAL-1.
  - v_cnt advances when h_cnt==H_TOTAL-1 and wraps at V_TOTAL-1.
  - H_TOTAL=1056 and V_TOTAL=628 at defaults.
- Image window: X_OFFSET <= h_cnt < X_OFFSET+(2^IMG_W_LOG2 << SCALE_LOG2), and the same rule on v_cnt with Y_OFFSET and IMG_H_LOG2.
- Image coordinates: img_x = (h_cnt-X_OFFSET) >> SCALE_LOG2; img_y is formed the same way. Implement them with sub-counters, not a divider.
- Address:
  - VRAM_addr = zero-extend {buf_active, img_y[IMG_H_LOG2-1:TILE_LOG2], img_x[IMG_W_LOG2-1:TILE_LOG2], img_y[TILE_LOG2-1:0], img_x[TILE_LOG2-1:0]}.
  - Registered one cycle after the counters.
  - Forced to 0 with VRAM_en=0 outside the window.
- Latency: total latency from counter value to pins is L = RAM_LATENCY+2 (address register, RAM, output register).
- Alignment: hsync, vsync, in_active, in_image and vblank are delayed through L-deep shift registers, so sync edges and RGB stay aligned at the pins.
- Output register, evaluated per delayed flags:
  - in_image: mandelbrot_color(VRAM_data).
  - Else in_active: BORDER_RGB.
  - Else: RGB = 0.
- Sync level: sync is asserted (at HSYNC_POL or VSYNC_POL) while the counter is inside the sync region, before the delay.
- Buffer swap:
  - frame_sel is sampled into buf_active only at h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.
  - A whole frame always reads a single buffer.
  - Toggling frame_sel mid-frame has no effect until that point.
- frame_start is high for exactly one cycle, L cycles after the counters reach (0,0).
- Reset, including reset mid-frame:
  - Counters, img counters and shift registers clear.
  - buf_active=0, VRAM_addr=0, VRAM_en=0, RGB=0, frame_start=0, vblank=0.
  - Syncs are at their inactive level.
  - The first post-reset output pixel appears L cycles after reset is released.
- Elaboration checks:
  - IMG_W_LOG2+IMG_H_LOG2+1 <= ADDR_W.
  - TILE_LOG2 <= min(IMG_W_LOG2, IMG_H_LOG2).
  - The scaled image fits in H_ACTIVE x V_ACTIVE.
  - RAM_LATENCY is in 1..4.
  - Any violation causes $fatal.

Decomposition:
- vga_pkg holds:
  - the timing struct typedef;
  - the SVGA_800x600 and VGA_640x480 timing constants;
  - the rgb12_t typedef;
  - the clog2-based width helpers.
- One sub-module, vga_timing_gen, holds the counters plus the sync, active and vblank flags.
- The top module adds windowing, addressing, the delay lines, buffer select and mandelbrot_color.

Test Plan:
- Defaults, free run for 2 frames → hsync low for 128 cycles every 1056; vsync low for 4 lines every 628; frame_start period 663168 cycles.
- Counters at (X_OFFSET, Y_OFFSET)=(144,44) → VRAM_addr=0, VRAM_en=1 one cycle later. At screen (146,44) → address 1. At (144+128,44) → address 4096 (tile column 1).
- RAM model at RAM_LATENCY=3 returns VRAM_data=addr[7:0] → RGB equals mandelbrot_color(data) exactly 5 cycles after counters. The hsync falling edge is at counter 840+5 relative to RGB.
- Pixel (0,0) or (799,599) outside the image → BORDER_RGB. Column 800 (blanking) → RGB=0, VRAM_en=0.
- Toggle frame_sel to 1 at mid-frame (v_cnt=300) → VRAM_addr[16]=0 for the rest of the frame. The next frame has bit 16=1 and buf_active=1.
- Assert reset for 1 cycle at v_cnt=400 → all outputs at reset values next cycle. The counter restarts at (0,0). frame_start follows L cycles after release.
